// File: rtl/rgmii_rx_frame_checker.sv
// RGMII RX frame checker: strips preamble/SFD, hides the FCS, checks CRC32 and reports
// per-frame status. Define RX_FRAME_STATS_EN to add the wrapping frame statistics counters.
module rgmii_rx_frame_checker #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MAX_PRE = 7
) (
  input  logic        clk375,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_val,
  input  logic        in_err,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic [7:0]  out_data,
  output logic        out_val,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_crc_ok,
  output logic        out_bad,
  output logic [10:0] out_len
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [31:0] stat_good,
  output logic [31:0] stat_crc,
  output logic [31:0] stat_len,
  output logic [31:0] stat_drop
`endif
);

  localparam logic [10:0] MinLen     = 11'(MIN_LEN);
  localparam logic [10:0] MaxLen     = 11'(MAX_LEN);
  localparam logic [7:0]  MaxPre     = 8'(MAX_PRE);
  localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

  typedef enum logic [1:0] {StIdle, StPre, StPay, StDrop} state_e;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  state_e state_q, state_d;

  logic [7:0]       pre_cnt_q, pre_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [10:0]      len_q, len_d;
  logic [3:0][7:0]  sr_q, sr_d;
  logic [2:0]       sr_cnt_q, sr_cnt_d;
  logic             emitted_q, emitted_d;
  logic             err_q, err_d;

  logic [7:0]       out_data_q, out_data_d;
  logic             out_val_q, out_val_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_crc_ok_q, out_crc_ok_d;
  logic             out_bad_q, out_bad_d;
  logic [10:0]      out_len_q, out_len_d;

  logic        byte_v, sof_v, pre_byte, pay_byte, end_frame, drop_evt;
  logic [10:0] len_inc;

  // in_eof wins over a coincident byte strobe
  assign byte_v   = in_val & ~in_eof;
  assign sof_v    = byte_v & in_sof;
  assign pre_byte = byte_v & ~in_sof & (state_q == StPre);
  assign pay_byte = byte_v & ~in_sof & (state_q == StPay);
  assign len_inc  = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;

  // A frame that produced payload ends either on in_eof or on an aborting in_sof
  assign end_frame = emitted_q & (state_q == StPay) & (in_eof | sof_v);
  assign drop_evt  = (state_d == StDrop) & (sof_v | pre_byte);

  always_ff @(posedge clk375) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_eof) begin
      state_d = StIdle;
    end else if (sof_v) begin
      state_d = (in_data == 8'h55) ? StPre : StDrop;
    end else if (pre_byte) begin
      if (in_data == 8'hD5) begin
        state_d = StPay;
      end else if (in_data != 8'h55 || pre_cnt_q >= MaxPre) begin
        state_d = StDrop;
      end
    end
  end

  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    crc_d        = crc_q;
    len_d        = len_q;
    sr_d         = sr_q;
    sr_cnt_d     = sr_cnt_q;
    emitted_d    = emitted_q;
    err_d        = err_q;
    out_data_d   = 8'h00;
    out_val_d    = 1'b0;
    out_sof_d    = 1'b0;
    out_eof_d    = 1'b0;
    out_crc_ok_d = 1'b0;
    out_bad_d    = 1'b0;
    out_len_d    = 11'd0;

    if (end_frame) begin
      out_eof_d    = 1'b1;
      out_len_d    = len_q;
      // an aborted frame never saw its FCS, so its CRC cannot be good
      out_crc_ok_d = ~sof_v & (crc_q == CrcResidue);
      out_bad_d    = ~out_crc_ok_d | (len_q < MinLen) | (len_q > MaxLen) | err_q | sof_v;
    end

    if (sof_v) begin
      pre_cnt_d = 8'd1;
      err_d     = in_err;
      crc_d     = CrcInit;
      len_d     = 11'd0;
      sr_cnt_d  = 3'd0;
      emitted_d = 1'b0;
    end else if (pre_byte) begin
      pre_cnt_d = pre_cnt_q + 8'd1;
      err_d     = err_q | in_err;
      if (in_data == 8'hD5) begin
        crc_d     = CrcInit;
        len_d     = 11'd0;
        sr_cnt_d  = 3'd0;
        emitted_d = 1'b0;
      end
    end else if (pay_byte) begin
      crc_d = crc_byte(crc_q, in_data);
      len_d = len_inc;
      sr_d  = {sr_q[2:0], in_data};
      err_d = err_q | in_err;
      // the last four bytes stay in the delay line, so the FCS is never emitted
      if (sr_cnt_q == 3'd4) begin
        if (len_inc <= MaxLen) begin
          out_val_d  = 1'b1;
          out_data_d = sr_q[3];
          out_sof_d  = ~emitted_q;
          emitted_d  = 1'b1;
        end
      end else begin
        sr_cnt_d = sr_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk375) begin
    if (!rst_n) begin
      pre_cnt_q    <= 8'd0;
      crc_q        <= CrcInit;
      len_q        <= 11'd0;
      sr_q         <= '0;
      sr_cnt_q     <= 3'd0;
      emitted_q    <= 1'b0;
      err_q        <= 1'b0;
      out_data_q   <= 8'h00;
      out_val_q    <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_crc_ok_q <= 1'b0;
      out_bad_q    <= 1'b0;
      out_len_q    <= 11'd0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      sr_q         <= sr_d;
      sr_cnt_q     <= sr_cnt_d;
      emitted_q    <= emitted_d;
      err_q        <= err_d;
      out_data_q   <= out_data_d;
      out_val_q    <= out_val_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      out_crc_ok_q <= out_crc_ok_d;
      out_bad_q    <= out_bad_d;
      out_len_q    <= out_len_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_val    = out_val_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign out_crc_ok = out_crc_ok_q;
  assign out_bad    = out_bad_q;
  assign out_len    = out_len_q;

`ifdef RX_FRAME_STATS_EN
  logic [31:0] stat_good_q, stat_good_d;
  logic [31:0] stat_crc_q, stat_crc_d;
  logic [31:0] stat_len_q, stat_len_d;
  logic [31:0] stat_drop_q, stat_drop_d;

  // counters move in the cycle the event is registered, i.e. as out_eof appears
  always_comb begin
    stat_good_d = stat_good_q;
    stat_crc_d  = stat_crc_q;
    stat_len_d  = stat_len_q;
    stat_drop_d = stat_drop_q;
    if (end_frame) begin
      if (!out_bad_d)    stat_good_d = stat_good_q + 32'd1;
      if (!out_crc_ok_d) stat_crc_d  = stat_crc_q + 32'd1;
      if ((len_q < MinLen) || (len_q > MaxLen)) stat_len_d = stat_len_q + 32'd1;
    end
    if (drop_evt) stat_drop_d = stat_drop_q + 32'd1;
  end

  always_ff @(posedge clk375) begin
    if (!rst_n) begin
      stat_good_q <= 32'd0;
      stat_crc_q  <= 32'd0;
      stat_len_q  <= 32'd0;
      stat_drop_q <= 32'd0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_crc_q  <= stat_crc_d;
      stat_len_q  <= stat_len_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_crc  = stat_crc_q;
  assign stat_len  = stat_len_q;
  assign stat_drop = stat_drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop_evt;
`endif

endmodule

// File: tb/tb_rgmii_rx_frame_checker.sv
// Bench for rgmii_rx_frame_checker: table of directed frames plus hand-written abort,
// mid-frame reset and eof/val collision sequences.
module tb_rgmii_rx_frame_checker;

  logic        clk375 = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_val, in_err, in_sof, in_eof;
  logic [7:0]  out_data;
  logic        out_val, out_sof, out_eof, out_crc_ok, out_bad;
  logic [10:0] out_len;
`ifdef RX_FRAME_STATS_EN
  logic [31:0] stat_good, stat_crc, stat_len, stat_drop;
`endif

  always #5 clk375 = ~clk375;

  rgmii_rx_frame_checker #(
    .MIN_LEN(64),
    .MAX_LEN(1522),
    .MAX_PRE(7)
  ) dut (
    .clk375    (clk375),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_val    (in_val),
    .in_err    (in_err),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .out_data  (out_data),
    .out_val   (out_val),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_crc_ok(out_crc_ok),
    .out_bad   (out_bad),
    .out_len   (out_len)
`ifdef RX_FRAME_STATS_EN
    ,
    .stat_good (stat_good),
    .stat_crc  (stat_crc),
    .stat_len  (stat_len),
    .stat_drop (stat_drop)
`endif
  );

  typedef struct {
    int npre;
    bit pre_bad;
    int plen;
    bit corrupt;
    int gap;
    int err_idx;
    int exp_n;
    bit exp_eof;
    bit exp_ok;
    bit exp_bad;
    int exp_len;
  } vec_t;

  vec_t vecs[14];

  int n_chk = 0;
  int n_fail = 0;
  int exp_good = 0, exp_crc = 0, exp_lenc = 0, exp_drop = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         sof_idx_q[$];
  bit         eof_ok_q[$];
  bit         eof_bad_q[$];
  int         eof_len_q[$];
  int         both_cnt = 0;
  int         stray_sof = 0;

  always @(negedge clk375) begin
    if (out_val) begin
      if (out_sof) sof_idx_q.push_back(rx_q.size());
      rx_q.push_back(out_data);
    end else if (out_sof) begin
      stray_sof++;
    end
    if (out_eof) begin
      eof_ok_q.push_back(out_crc_ok);
      eof_bad_q.push_back(out_bad);
      eof_len_q.push_back(int'(out_len));
    end
    if (out_val && out_eof) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int npre, input bit pre_bad, input int plen, input int base,
                       input bit corrupt, input bit with_fcs);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    tx_q.delete();
    for (int i = 0; i < npre; i++) tx_q.push_back((pre_bad && i == 2) ? 8'h54 : 8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 0; i < plen; i++) begin
      b = 8'(base + i);
      tx_q.push_back(b);
      c = crc_upd(c, b);
    end
    if (with_fcs) begin
      c = ~c;
      tx_q.push_back(c[7:0]);
      tx_q.push_back(c[15:8]);
      tx_q.push_back(c[23:16]);
      tx_q.push_back(c[31:24]);
      if (corrupt) tx_q[tx_q.size() - 1] = tx_q[tx_q.size() - 1] ^ 8'h01;
    end
  endtask

  // Called at a negedge; returns at a negedge
  task automatic send_byte(input logic [7:0] d, input bit sof, input bit err, input int gap);
    in_data = d;
    in_val  = 1'b1;
    in_sof  = sof;
    in_err  = err;
    @(negedge clk375);
    in_val = 1'b0;
    in_sof = 1'b0;
    in_err = 1'b0;
    repeat (gap - 1) @(negedge clk375);
  endtask

  task automatic send_bytes(input int gap, input int err_idx);
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], i == 0, i == err_idx, gap);
  endtask

  task automatic send_eof();
    in_eof = 1'b1;
    @(negedge clk375);
    in_eof = 1'b0;
    repeat (4) @(negedge clk375);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    sof_idx_q.delete();
    eof_ok_q.delete();
    eof_bad_q.delete();
    eof_len_q.delete();
  endtask

  task automatic tally(input bit ok, input bit bad, input int len);
    if (!bad) exp_good++;
    if (!ok) exp_crc++;
    if (len < 64 || len > 1522) exp_lenc++;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   errs;
    int   base;
    v    = vecs[k];
    base = k * 16;
    clear_mon();
    build(v.npre, v.pre_bad, v.plen, base, v.corrupt, 1'b1);
    send_bytes(v.gap, v.err_idx);
    send_eof();
    check($sformatf("v%0d_eof_count", k), eof_ok_q.size(), v.exp_eof ? 1 : 0);
    check($sformatf("v%0d_nbytes", k), rx_q.size(), v.exp_n);
    errs = 0;
    for (int i = 0; i < rx_q.size() && i < v.exp_n; i++) begin
      if (rx_q[i] !== 8'(base + i)) errs++;
    end
    check($sformatf("v%0d_data_errs", k), errs, 0);
    if (v.exp_n > 0) begin
      check($sformatf("v%0d_sof_first_only", k),
            (sof_idx_q.size() == 1 && sof_idx_q[0] == 0) ? 1 : 0, 1);
    end
    if (v.exp_eof && eof_ok_q.size() > 0) begin
      check($sformatf("v%0d_crc_ok", k), eof_ok_q[0], v.exp_ok);
      check($sformatf("v%0d_bad", k), eof_bad_q[0], v.exp_bad);
      check($sformatf("v%0d_len", k), eof_len_q[0], v.exp_len);
      tally(v.exp_ok, v.exp_bad, v.exp_len);
    end
    if (v.pre_bad || v.npre > 7) exp_drop++;
  endtask

  initial begin
    int errs;
    //            npre bad plen  cor gap  err  n     eof ok bad len
    vecs[0]  = '{7, 0, 60,   0, 1,   -1, 60,   1, 1, 0, 64};
    vecs[1]  = '{7, 0, 60,   1, 1,   -1, 60,   1, 0, 1, 64};
    vecs[2]  = '{7, 1, 60,   0, 1,   -1, 0,    0, 0, 0, 0};
    vecs[3]  = '{7, 0, 20,   0, 1,   -1, 20,   1, 1, 1, 24};
    vecs[4]  = '{7, 0, 60,   0, 3,   -1, 60,   1, 1, 0, 64};
    vecs[5]  = '{7, 0, 60,   0, 100, -1, 60,   1, 1, 0, 64};
    vecs[6]  = '{8, 0, 60,   0, 1,   -1, 0,    0, 0, 0, 0};
    vecs[7]  = '{7, 0, 0,    0, 1,   -1, 0,    0, 0, 0, 0};
    vecs[8]  = '{7, 0, 1,    0, 1,   -1, 1,    1, 1, 1, 5};
    vecs[9]  = '{7, 0, 60,   0, 1,   13, 60,   1, 1, 1, 64};
    vecs[10] = '{1, 0, 60,   0, 1,   -1, 60,   1, 1, 0, 64};
    vecs[11] = '{7, 0, 1518, 0, 1,   -1, 1518, 1, 1, 0, 1522};
    vecs[12] = '{7, 0, 1519, 0, 1,   -1, 1518, 1, 1, 1, 1523};
    vecs[13] = '{7, 0, 2050, 0, 1,   -1, 1518, 1, 1, 1, 2047};

    rst_n   = 1'b0;
    in_data = 8'h00;
    in_val  = 1'b0;
    in_err  = 1'b0;
    in_sof  = 1'b0;
    in_eof  = 1'b0;
    repeat (3) @(negedge clk375);
    check("reset_strobes", {out_val, out_sof, out_eof, out_crc_ok, out_bad}, 0);
    check("reset_data_len", {out_data, out_len}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk375);

    // Reset in the middle of a payload: the fragment must not report an eof
    build(7, 1'b0, 20, 8'h40, 1'b0, 1'b0);
    send_bytes(1, -1);
    rst_n = 1'b0;
    @(negedge clk375);
    rst_n = 1'b1;
    check("midrst_outputs", {out_val, out_eof, out_data, out_len}, 0);
    clear_mon();
    build(7, 1'b0, 60, 8'h80, 1'b0, 1'b1);
    send_bytes(1, -1);
    send_eof();
    check("midrst_eof_count", eof_ok_q.size(), 1);
    check("midrst_nbytes", rx_q.size(), 60);
    if (eof_ok_q.size() > 0) begin
      check("midrst_crc_ok", eof_ok_q[0], 1);
      check("midrst_bad", eof_bad_q[0], 0);
    end
    tally(1'b1, 1'b0, 64);

    for (int k = 0; k < 14; k++) run_vec(k);

    // Frame A aborted by frame B's sof after 30 payload bytes
    clear_mon();
    build(7, 1'b0, 30, 8'h10, 1'b0, 1'b0);
    send_bytes(2, -1);
    build(7, 1'b0, 60, 8'h20, 1'b0, 1'b1);
    send_bytes(1, -1);
    send_eof();
    check("abort_eof_count", eof_ok_q.size(), 2);
    check("abort_nbytes", rx_q.size(), 86);
    check("abort_sof_pos", (sof_idx_q.size() == 2 && sof_idx_q[0] == 0 && sof_idx_q[1] == 26)
          ? 1 : 0, 1);
    if (eof_ok_q.size() == 2) begin
      check("abort_a_bad", eof_bad_q[0], 1);
      check("abort_b_crc_ok", eof_ok_q[1], 1);
      check("abort_b_bad", eof_bad_q[1], 0);
      check("abort_b_len", eof_len_q[1], 64);
    end
    errs = 0;
    for (int i = 0; i < rx_q.size() && i < 86; i++) begin
      if (rx_q[i] !== ((i < 26) ? 8'(8'h10 + i) : 8'(8'h20 + i - 26))) errs++;
    end
    check("abort_data_errs", errs, 0);
    tally(1'b0, 1'b1, 30);
    tally(1'b1, 1'b0, 64);

    // in_eof together with a byte strobe: the byte is discarded
    clear_mon();
    build(7, 1'b0, 60, 8'h30, 1'b0, 1'b1);
    send_bytes(1, -1);
    in_data = 8'hAA;
    in_val  = 1'b1;
    in_eof  = 1'b1;
    @(negedge clk375);
    in_val = 1'b0;
    in_eof = 1'b0;
    repeat (4) @(negedge clk375);
    check("eofval_eof_count", eof_ok_q.size(), 1);
    check("eofval_nbytes", rx_q.size(), 60);
    if (eof_ok_q.size() > 0) begin
      check("eofval_crc_ok", eof_ok_q[0], 1);
      check("eofval_bad", eof_bad_q[0], 0);
      check("eofval_len", eof_len_q[0], 64);
    end
    tally(1'b1, 1'b0, 64);

    check("val_eof_overlap", both_cnt, 0);
    check("stray_sof", stray_sof, 0);
`ifdef RX_FRAME_STATS_EN
    check("stat_good", stat_good, exp_good);
    check("stat_crc", stat_crc, exp_crc);
    check("stat_len", stat_len, exp_lenc);
    check("stat_drop", stat_drop, exp_drop);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
